// File: rtl/i2c_cfg_slave_pkg.sv
// Shared definitions for the I2C configuration target: FSM states, bus
// symbol values and the DVI encoder register map.
package i2c_cfg_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  // Bit counter values inside an ACK slot: 8 = ACK clock not yet seen, 9 = seen.
  localparam logic [3:0] BIT_ACK_DRIVE = 4'd8;
  localparam logic [3:0] BIT_ACK_DONE  = 4'd9;

  localparam logic [7:0] DVI_REG_PM   = 8'h49;
  localparam logic [7:0] DVI_REG_CM   = 8'h21;
  localparam logic [7:0] DVI_REG_TPCP = 8'h33;
  localparam logic [7:0] DVI_REG_TPD  = 8'h34;
  localparam logic [7:0] DVI_REG_TPF  = 8'h36;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchronisers with edge, START and STOP detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic SCL_in,
  input  logic SDA_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl;
  logic                   sda_rise;
  logic                   sda_fall;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign sda_rise  = sda & ~sda_d;
  assign sda_fall  = ~sda & sda_d;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

endmodule

// File: rtl/i2c_cfg_slave.sv
// I2C target with an 8-bit register pointer: decodes writes into register
// strobes and serves reads from an external register file.
module i2c_cfg_slave
  import i2c_cfg_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'b1110110,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       xfer_done
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .SCL_in   (SCL_in),
    .SDA_in   (SDA_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_state_t    state, state_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    rx_sr, rx_nxt;
  logic [7:0]    tx_sr, tx_nxt;
  logic [7:0]    addr_nxt, wdata_nxt;
  logic          wr_en_nxt, done_nxt, busy_nxt, oe_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          oe_tgt, tgt_nxt;
  logic          matched, matched_nxt;
  logic          rw, rw_nxt;
  logic [7:0]    byte_in;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '1;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      xfer_done   <= 1'b0;
      busy        <= 1'b0;
      SDA_oe      <= 1'b0;
      hold_cnt    <= '0;
      oe_tgt      <= 1'b0;
      matched     <= 1'b0;
      rw          <= WRITE;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      rx_sr       <= rx_nxt;
      tx_sr       <= tx_nxt;
      reg_addr    <= addr_nxt;
      reg_wr_data <= wdata_nxt;
      reg_wr_en   <= wr_en_nxt;
      xfer_done   <= done_nxt;
      busy        <= busy_nxt;
      SDA_oe      <= oe_nxt;
      hold_cnt    <= hold_nxt;
      oe_tgt      <= tgt_nxt;
      matched     <= matched_nxt;
      rw          <= rw_nxt;
    end
  end

  // SDA_oe updates are queued on scl_fall as (hold_cnt, oe_tgt) and applied
  // HOLD_CYCLES later, so the line only moves while SCL is low.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    rx_nxt      = rx_sr;
    tx_nxt      = tx_sr;
    addr_nxt    = reg_addr;
    wdata_nxt   = reg_wr_data;
    wr_en_nxt   = 1'b0;
    done_nxt    = 1'b0;
    busy_nxt    = busy;
    oe_nxt      = SDA_oe;
    hold_nxt    = hold_cnt;
    tgt_nxt     = oe_tgt;
    matched_nxt = matched;
    rw_nxt      = rw;
    byte_in     = {rx_sr[6:0], sda};

    if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - HOLD_ONE;
      if (hold_cnt == HOLD_ONE) oe_nxt = oe_tgt;
    end

    if (stop_det) begin
      state_nxt   = ST_IDLE;
      busy_nxt    = 1'b0;
      oe_nxt      = 1'b0;
      hold_nxt    = '0;
      bit_cnt_nxt = '0;
      done_nxt    = matched;
      matched_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt   = ST_ADDR;
      busy_nxt    = 1'b1;
      oe_nxt      = 1'b0;
      hold_nxt    = '0;
      bit_cnt_nxt = '0;
      matched_nxt = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR, ST_REG, ST_WDATA, ST_RDATA: begin
          rx_nxt      = byte_in;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            case (state)
              ST_ADDR: begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_nxt   = ST_ADDR_ACK;
                  matched_nxt = 1'b1;
                  rw_nxt      = byte_in[0];
                end else begin
                  state_nxt = ST_IGNORE;
                end
              end
              ST_REG: begin
                addr_nxt  = byte_in;
                state_nxt = ST_REG_ACK;
              end
              ST_WDATA: begin
                wdata_nxt = byte_in;
                wr_en_nxt = 1'b1;
                state_nxt = ST_WDATA_ACK;
              end
              default: state_nxt = ST_RDATA_ACK;
            endcase
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (bit_cnt == BIT_ACK_DRIVE) bit_cnt_nxt = BIT_ACK_DONE;
        end
        ST_RDATA_ACK: begin
          if (bit_cnt == BIT_ACK_DRIVE) begin
            bit_cnt_nxt = BIT_ACK_DONE;
            // Advance the pointer now so reg_rd_data is valid by the closing fall.
            if (sda == I2C_ACK) addr_nxt = reg_addr + 8'd1;
            else                state_nxt = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (bit_cnt == BIT_ACK_DRIVE) begin
            hold_nxt = HOLD_LOAD;
            tgt_nxt  = 1'b1;
          end else if (bit_cnt == BIT_ACK_DONE) begin
            bit_cnt_nxt = '0;
            hold_nxt    = HOLD_LOAD;
            tgt_nxt     = 1'b0;
            state_nxt   = ST_WDATA;
            if (state == ST_ADDR_ACK) begin
              if (rw == READ) begin
                state_nxt = ST_RDATA;
                tx_nxt    = {reg_rd_data[6:0], 1'b1};
                tgt_nxt   = ~reg_rd_data[7];
              end else begin
                state_nxt = ST_REG;
              end
            end else if (state == ST_WDATA_ACK) begin
              addr_nxt = reg_addr + 8'd1;
            end
          end
        end
        ST_RDATA: begin
          if (bit_cnt != '0) begin
            hold_nxt = HOLD_LOAD;
            tgt_nxt  = ~tx_sr[7];
            tx_nxt   = {tx_sr[6:0], 1'b1};
          end
        end
        ST_RDATA_ACK: begin
          if (bit_cnt == BIT_ACK_DRIVE) begin
            hold_nxt = HOLD_LOAD;
            tgt_nxt  = 1'b0;
          end else if (bit_cnt == BIT_ACK_DONE) begin
            bit_cnt_nxt = '0;
            state_nxt   = ST_RDATA;
            tx_nxt      = {reg_rd_data[6:0], 1'b1};
            hold_nxt    = HOLD_LOAD;
            tgt_nxt     = ~reg_rd_data[7];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Directed bench for i2c_cfg_slave: bit-level I2C master, register file
// model and a scoreboard of expected register-write strobes.
module tb_i2c_cfg_slave;
  import i2c_cfg_slave_pkg::*;

  localparam int Q = 8;

  logic       Clk;
  logic       Reset_n;
  logic       SCL_in;
  logic       SDA_in;
  logic       SDA_oe;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       busy;
  logic       xfer_done;

  logic       scl_m;
  logic       sda_m;
  logic [7:0] mem [256];

  int         checks;
  int         errors;
  int         wr_cnt;
  int         done_cnt;
  logic       oe_prev;
  logic       oe_ever;
  logic [15:0] exp_q[$];

  i2c_cfg_slave #(
    .SLAVE_ADDR (7'b1110110),
    .SYNC_STAGES(2),
    .HOLD_CYCLES(4)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .SCL_in     (SCL_in),
    .SDA_in     (SDA_in),
    .SDA_oe     (SDA_oe),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .reg_rd_data(reg_rd_data),
    .busy       (busy),
    .xfer_done  (xfer_done)
  );

  assign SCL_in      = scl_m;
  assign SDA_in      = sda_m & ~SDA_oe;
  assign reg_rd_data = mem[reg_addr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic bit_x(input logic v, output logic s);
    sda_m = v;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    s = SDA_in;   wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    acked = (s === I2C_ACK);
  endtask

  task automatic rd_byte(input logic mbit, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_x(1'b1, s);
      d = {d[6:0], s};
    end
    bit_x(mbit, s);
  endtask

  // Scoreboard: every strobe must match the oldest expected {addr,data}.
  always @(negedge Clk) begin
    logic [15:0] e;
    if (reg_wr_en === 1'b1) begin
      wr_cnt++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("wr_strobe", 32'({reg_addr, reg_wr_data}), 32'(e));
    end
    if (xfer_done === 1'b1) done_cnt++;
    if (SDA_oe !== oe_prev) begin
      oe_ever = 1'b1;
      chk("oe_change_scl_low", 32'(scl_m), 32'(1'b0));
    end
    oe_prev = SDA_oe;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic       a1, a2, a3;
    logic [7:0] rd;
    logic       s;
    int         w0, d0;

    checks = 0; errors = 0; wr_cnt = 0; done_cnt = 0;
    oe_prev = 1'b0; oe_ever = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[DVI_REG_TPCP] = 8'h08;
    Reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    chk("rst_sda_oe", 32'(SDA_oe), 32'(1'b0));
    chk("rst_wr_en", 32'(reg_wr_en), 32'(1'b0));
    chk("rst_reg_addr", 32'(reg_addr), 32'(8'h00));
    chk("rst_wr_data", 32'(reg_wr_data), 32'(8'h00));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_xfer_done", 32'(xfer_done), 32'(1'b0));
    Reset_n = 1'b1;
    wait_clk(4);

    // Single register write
    i2c_start();
    chk("busy_after_start", 32'(busy), 32'(1'b1));
    exp_q.push_back({DVI_REG_PM, 8'hC0});
    wr_byte(8'hEC, a1); wr_byte(DVI_REG_PM, a2); wr_byte(8'hC0, a3);
    chk("t1_ack_addr", 32'(a1), 32'(1'b1));
    chk("t1_ack_reg", 32'(a2), 32'(1'b1));
    chk("t1_ack_data", 32'(a3), 32'(1'b1));
    i2c_stop();
    chk("t1_busy_after_stop", 32'(busy), 32'(1'b0));
    chk("t1_done_cnt", 32'(done_cnt), 32'(1));
    chk("t1_wr_cnt", 32'(wr_cnt), 32'(1));

    // Foreign address: no drive, no strobes
    oe_ever = 1'b0; w0 = wr_cnt; d0 = done_cnt;
    i2c_start();
    wr_byte(8'h3A, a1); wr_byte(DVI_REG_PM, a2); wr_byte(8'h55, a3);
    i2c_stop();
    chk("t2_ack_addr", 32'(a1), 32'(1'b0));
    chk("t2_oe_ever", 32'(oe_ever), 32'(1'b0));
    chk("t2_wr_cnt", 32'(wr_cnt), 32'(w0));
    chk("t2_done_cnt", 32'(done_cnt), 32'(d0));

    // Burst write with pointer wrap
    w0 = wr_cnt;
    exp_q.push_back(16'hFE11); exp_q.push_back(16'hFF22); exp_q.push_back(16'h0033);
    i2c_start();
    wr_byte(8'hEC, a1); wr_byte(8'hFE, a2);
    chk("t3_ack_addr", 32'(a1), 32'(1'b1));
    wr_byte(8'h11, a1); wr_byte(8'h22, a2); wr_byte(8'h33, a3);
    chk("t3_ack_d3", 32'(a3), 32'(1'b1));
    i2c_stop();
    chk("t3_wr_cnt", 32'(wr_cnt), 32'(w0 + 3));
    chk("t3_done_cnt", 32'(done_cnt), 32'(2));

    // Combined format: set pointer, repeated START, read one byte, NACK
    i2c_start();
    wr_byte(8'hEC, a1); wr_byte(DVI_REG_TPCP, a2);
    i2c_start();
    wr_byte(8'hED, a3);
    chk("t4_ack_rd_addr", 32'(a3), 32'(1'b1));
    rd_byte(I2C_NACK, rd);
    chk("t4_rd_data", 32'(rd), 32'(8'h08));
    wait_clk(Q);
    chk("t4_sda_released", 32'(SDA_oe), 32'(1'b0));
    chk("t4_reg_addr_kept", 32'(reg_addr), 32'(DVI_REG_TPCP));
    i2c_stop();
    chk("t4_done_cnt", 32'(done_cnt), 32'(3));

    // Reset while the target drives ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_x(1'(8'hEC >> i), s);
    sda_m = 1'b1;
    wait_clk(Q);
    chk("t5_ack_driven", 32'(SDA_oe), 32'(1'b1));
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    chk("t5_oe_after_reset", 32'(SDA_oe), 32'(1'b0));
    Reset_n = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
    i2c_stop();
    chk("t5_done_after_reset", 32'(done_cnt), 32'(3));
    w0 = wr_cnt;
    exp_q.push_back({DVI_REG_TPD, 8'h5A});
    i2c_start();
    wr_byte(8'hEC, a1); wr_byte(DVI_REG_TPD, a2); wr_byte(8'h5A, a3);
    i2c_stop();
    chk("t5_ack_data", 32'(a3), 32'(1'b1));
    chk("t5_wr_cnt", 32'(wr_cnt), 32'(w0 + 1));

    // START after 5 data bits truncates the byte
    w0 = wr_cnt;
    i2c_start();
    wr_byte(8'hEC, a1); wr_byte(DVI_REG_CM, a2);
    for (int i = 0; i < 5; i++) bit_x(1'b1, s);
    exp_q.push_back({DVI_REG_TPF, 8'h77});
    i2c_start();
    wr_byte(8'hEC, a1); wr_byte(DVI_REG_TPF, a2); wr_byte(8'h77, a3);
    chk("t6_ack_addr", 32'(a1), 32'(1'b1));
    i2c_stop();
    chk("t6_wr_cnt", 32'(wr_cnt), 32'(w0 + 1));
    chk("t6_done_cnt", 32'(done_cnt), 32'(5));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
